// File: rtl/id_ex_stage_if.sv
// Bus between decode, the ID/EX register and the EX stage: upstream handshake,
// decoded fields, writeback bus, ALU feedback and the registered EX-side outputs.
interface id_ex_stage_if #(
    parameter int W  = 8,
    parameter int RA = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_rs_val;
    logic [W-1:0]  in_rt_val;
    logic [W-1:0]  in_imm;
    logic          in_use_imm;
    logic [2:0]    in_func;
    logic [RA-1:0] in_rs;
    logic [RA-1:0] in_rt;
    logic [RA-1:0] in_rd;
    logic          in_wen;
    logic          wb_wen;
    logic [RA-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic [W-1:0]  alu_result;
    logic          flush;
    logic          ex_ready;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [2:0]    func;
    logic          ex_valid;
    logic [RA-1:0] ex_rd;
    logic          ex_wen;

    modport slave (
        input  in_valid, in_rs_val, in_rt_val, in_imm, in_use_imm, in_func,
               in_rs, in_rt, in_rd, in_wen, wb_wen, wb_rd, wb_data,
               alu_result, flush, ex_ready,
        output in_ready, op1, op2, func, ex_valid, ex_rd, ex_wen
    );

    modport master (
        output in_valid, in_rs_val, in_rt_val, in_imm, in_use_imm, in_func,
               in_rs, in_rt, in_rd, in_wen, wb_wen, wb_rd, wb_data,
               alu_result, flush, ex_ready,
        input  in_ready, op1, op2, func, ex_valid, ex_rd, ex_wen
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and stall hold.
// Operand forwarding (EX over WB, never for r0) is built only with ID_EX_FORWARD_EN.
module id_ex_stage #(
    parameter int W  = 8,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    logic [W-1:0]  op1_q, op1_d;
    logic [W-1:0]  op2_q, op2_d;
    logic [2:0]    func_q, func_d;
    logic [RA-1:0] ex_rd_q, ex_rd_d;
    logic          ex_wen_q, ex_wen_d;
    logic          ex_valid_q, ex_valid_d;
    logic [W-1:0]  rs_fwd, rt_fwd;
    logic          load;

    assign bus.in_ready = !ex_valid_q || bus.ex_ready;
    assign load         = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef ID_EX_FORWARD_EN
    // The held instruction's result is younger than the writeback bus, so it wins.
    always_comb begin
        rs_fwd = bus.in_rs_val;
        if (ex_valid_q && ex_wen_q && (ex_rd_q == bus.in_rs) && (bus.in_rs != '0))
            rs_fwd = bus.alu_result;
        else if (bus.wb_wen && (bus.wb_rd == bus.in_rs) && (bus.in_rs != '0))
            rs_fwd = bus.wb_data;

        rt_fwd = bus.in_rt_val;
        if (ex_valid_q && ex_wen_q && (ex_rd_q == bus.in_rt) && (bus.in_rt != '0))
            rt_fwd = bus.alu_result;
        else if (bus.wb_wen && (bus.wb_rd == bus.in_rt) && (bus.in_rt != '0))
            rt_fwd = bus.wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.alu_result, bus.wb_wen, bus.wb_rd, bus.wb_data,
                          bus.in_rs, bus.in_rt};
    assign rs_fwd = bus.in_rs_val;
    assign rt_fwd = bus.in_rt_val;
`endif

    always_comb begin
        op1_d      = op1_q;
        op2_d      = op2_q;
        func_d     = func_q;
        ex_rd_d    = ex_rd_q;
        ex_wen_d   = ex_wen_q;
        ex_valid_d = ex_valid_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_wen_d   = 1'b0;
        end else if (load) begin
            op1_d      = rs_fwd;
            op2_d      = bus.in_use_imm ? bus.in_imm : rt_fwd;
            func_d     = bus.in_func;
            ex_rd_d    = bus.in_rd;
            ex_wen_d   = bus.in_wen;
            ex_valid_d = 1'b1;
        end else if (bus.ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q      <= '0;
            op2_q      <= '0;
            func_q     <= '0;
            ex_rd_q    <= '0;
            ex_wen_q   <= 1'b0;
            ex_valid_q <= 1'b0;
        end else begin
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            func_q     <= func_d;
            ex_rd_q    <= ex_rd_d;
            ex_wen_q   <= ex_wen_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    assign bus.op1      = op1_q;
    assign bus.op2      = op2_q;
    assign bus.func     = func_q;
    assign bus.ex_rd    = ex_rd_q;
    assign bus.ex_wen   = ex_wen_q;
    assign bus.ex_valid = ex_valid_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, directed corner sequences
// and random traffic against a register-transfer reference model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    id_ex_stage_if #(.W(8), .RA(3)) bus ();
    id_ex_stage    #(.W(8), .RA(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference view of the instruction held in EX.
    logic       m_valid, m_wen;
    logic [7:0] m_op1, m_op2;
    logic [2:0] m_func, m_rd;

    typedef struct {
        logic [7:0] rs_val, rt_val, imm;
        logic       use_imm;
        logic [2:0] fn, rs, rt, rd;
        logic       wb_wen;
        logic [2:0] wb_rd;
        logic [7:0] wb_data;
        logic [7:0] e_op1, e_op2;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] src_val(input logic [2:0] src, input logic [7:0] regval);
`ifdef ID_EX_FORWARD_EN
        if (src != 3'd0 && m_valid && m_wen && m_rd == src) return bus.alu_result;
        if (src != 3'd0 && bus.wb_wen && bus.wb_rd == src) return bus.wb_data;
`endif
        return regval;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wen = 0; m_op1 = 0; m_op2 = 0; m_func = 0; m_rd = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".op1"},      bus.op1,      m_op1);
        chk({tag, ".op2"},      bus.op2,      m_op2);
        chk({tag, ".func"},     bus.func,     m_func);
        chk({tag, ".ex_rd"},    bus.ex_rd,    m_rd);
        chk({tag, ".ex_wen"},   bus.ex_wen,   m_wen);
        chk({tag, ".ex_valid"}, bus.ex_valid, m_valid);
    endtask

    // One clock: predict from the current inputs, clock, compare.
    task automatic tick(input string tag);
        logic accept, n_valid, n_wen;
        logic [7:0] n_op1, n_op2;
        logic [2:0] n_func, n_rd;
        #1;
        chk({tag, ".in_ready"}, bus.in_ready, !m_valid || bus.ex_ready);
        accept = bus.in_valid && (!m_valid || bus.ex_ready);
        n_valid = m_valid; n_wen = m_wen; n_op1 = m_op1; n_op2 = m_op2;
        n_func = m_func; n_rd = m_rd;
        if (bus.flush) begin
            n_valid = 0; n_wen = 0;
        end else if (accept) begin
            n_op1   = src_val(bus.in_rs, bus.in_rs_val);
            n_op2   = bus.in_use_imm ? bus.in_imm : src_val(bus.in_rt, bus.in_rt_val);
            n_func  = bus.in_func;
            n_rd    = bus.in_rd;
            n_wen   = bus.in_wen;
            n_valid = 1;
        end else if (bus.ex_ready) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_wen = n_wen; m_op1 = n_op1; m_op2 = n_op2;
        m_func = n_func; m_rd = n_rd;
        check_all(tag);
    endtask

    task automatic set_in(input logic [7:0] rsv, input logic [7:0] rtv, input logic [7:0] imm,
                          input logic ui, input logic [2:0] fn, input logic [2:0] rs,
                          input logic [2:0] rt, input logic [2:0] rd, input logic wen);
        bus.in_valid = 1; bus.in_rs_val = rsv; bus.in_rt_val = rtv; bus.in_imm = imm;
        bus.in_use_imm = ui; bus.in_func = fn; bus.in_rs = rs; bus.in_rt = rt;
        bus.in_rd = rd; bus.in_wen = wen;
    endtask

    task automatic set_wb(input logic en, input logic [2:0] rd, input logic [7:0] d);
        bus.wb_wen = en; bus.wb_rd = rd; bus.wb_data = d;
    endtask

    initial begin
        logic [7:0] fwd_exp;
        rst_n = 0;
        set_in(8'h00, 8'h00, 8'h00, 0, 3'd0, 3'd0, 3'd0, 3'd0, 0);
        bus.in_valid = 0; bus.flush = 0; bus.ex_ready = 1; bus.alu_result = 0;
        set_wb(0, 3'd0, 8'h00);
        model_reset();

        tbl[0] = '{8'hF8, 8'h01, 8'h00, 1'b0, 3'd2, 3'd1, 3'd2, 3'd4, 1'b0, 3'd0, 8'h00, 8'hF8, 8'h01};
        tbl[1] = '{8'h10, 8'h20, 8'h5A, 1'b1, 3'd5, 3'd3, 3'd4, 3'd6, 1'b0, 3'd0, 8'h00, 8'h10, 8'h5A};
        tbl[2] = '{8'hFF, 8'h00, 8'h77, 1'b0, 3'd7, 3'd7, 3'd6, 3'd1, 1'b0, 3'd0, 8'h00, 8'hFF, 8'h00};
        tbl[3] = '{8'h00, 8'hFF, 8'h80, 1'b1, 3'd0, 3'd2, 3'd2, 3'd7, 1'b0, 3'd0, 8'h00, 8'h00, 8'h80};
`ifdef ID_EX_FORWARD_EN
        tbl[4] = '{8'h33, 8'h44, 8'h00, 1'b0, 3'd1, 3'd5, 3'd6, 3'd2, 1'b1, 3'd5, 8'h99, 8'h99, 8'h44};
`else
        tbl[4] = '{8'h33, 8'h44, 8'h00, 1'b0, 3'd1, 3'd5, 3'd6, 3'd2, 1'b1, 3'd5, 8'h99, 8'h33, 8'h44};
`endif
        tbl[5] = '{8'h12, 8'h34, 8'h00, 1'b0, 3'd3, 3'd0, 3'd0, 3'd5, 1'b1, 3'd0, 8'hEE, 8'h12, 8'h34};

        #2;
        chk("reset.op1", bus.op1, 0);
        chk("reset.ex_valid", bus.ex_valid, 0);
        chk("reset.in_ready", bus.in_ready, 1);
        #10 rst_n = 1;
        @(posedge clk); #1;
        check_all("post_reset");

        // Vector table: each applied with ex_ready=1, so it always loads.
        for (int i = 0; i < 6; i++) begin
            set_in(tbl[i].rs_val, tbl[i].rt_val, tbl[i].imm, tbl[i].use_imm, tbl[i].fn,
                   tbl[i].rs, tbl[i].rt, tbl[i].rd, 0);
            set_wb(tbl[i].wb_wen, tbl[i].wb_rd, tbl[i].wb_data);
            bus.ex_ready = 1;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.op1_tbl", i), bus.op1, tbl[i].e_op1);
            chk($sformatf("vec%0d.op2_tbl", i), bus.op2, tbl[i].e_op2);
            chk($sformatf("vec%0d.func_tbl", i), bus.func, tbl[i].fn);
            chk($sformatf("vec%0d.valid_tbl", i), bus.ex_valid, 1);
        end
        set_wb(0, 3'd0, 8'h00);

        // Stall: held A must not move for 3 cycles while B waits.
        set_in(8'hA1, 8'hA2, 8'h00, 0, 3'd4, 3'd1, 3'd2, 3'd3, 0);
        tick("stall_load");
        bus.ex_ready = 0;
        set_in(8'hB1, 8'hB2, 8'h00, 0, 3'd6, 3'd1, 3'd2, 3'd4, 0);
        for (int c = 0; c < 3; c++) begin
            bus.alu_result = 8'($urandom);
            set_wb(1, 3'd1, 8'($urandom));
            tick("stall");
            chk("stall.in_ready", bus.in_ready, 0);
            chk("stall.op1", bus.op1, 8'hA1);
            chk("stall.op2", bus.op2, 8'hA2);
            chk("stall.func", bus.func, 3'd4);
        end
        set_wb(0, 3'd0, 8'h00);
        bus.ex_ready = 1;
        tick("unstall");
        chk("unstall.op1", bus.op1, 8'hB1);
        chk("unstall.func", bus.func, 3'd6);

        // Flush beats a simultaneous load.
        set_in(8'hC1, 8'hC2, 8'h00, 0, 3'd1, 3'd1, 3'd2, 3'd5, 1);
        bus.flush = 1;
        tick("flush");
        chk("flush.ex_valid", bus.ex_valid, 0);
        chk("flush.ex_wen", bus.ex_wen, 0);
        bus.flush = 0;

        // Forwarding: held rd=3 writes; EX result beats WB.
        set_in(8'h01, 8'h02, 8'h00, 0, 3'd0, 3'd1, 3'd2, 3'd3, 1);
        tick("fwd_prod");
        bus.alu_result = 8'h7F;
        set_wb(1, 3'd3, 8'h11);
        set_in(8'h00, 8'h09, 8'h00, 0, 3'd1, 3'd3, 3'd1, 3'd3, 1);
`ifdef ID_EX_FORWARD_EN
        fwd_exp = 8'h7F;
`else
        fwd_exp = 8'h00;
`endif
        tick("fwd_ex");
        chk("fwd_ex.op1", bus.op1, fwd_exp);
        set_in(8'h22, 8'h09, 8'h00, 0, 3'd1, 3'd0, 3'd1, 3'd2, 1);
        tick("fwd_r0");
        chk("fwd_r0.op1", bus.op1, 8'h22);
        // Held now rd=2; WB-only hazard on r4.
        set_wb(1, 3'd4, 8'h11);
        set_in(8'h00, 8'h09, 8'h00, 0, 3'd1, 3'd4, 3'd1, 3'd2, 1);
`ifdef ID_EX_FORWARD_EN
        fwd_exp = 8'h11;
`else
        fwd_exp = 8'h00;
`endif
        tick("fwd_wb");
        chk("fwd_wb.op1", bus.op1, fwd_exp);
        // Held rd=2 writing: immediate overrides rt hazard; rs hazard on r2.
        bus.alu_result = 8'h66;
        set_wb(0, 3'd0, 8'h00);
        set_in(8'h44, 8'h55, 8'h05, 1, 3'd2, 3'd2, 3'd2, 3'd6, 0);
`ifdef ID_EX_FORWARD_EN
        fwd_exp = 8'h66;
`else
        fwd_exp = 8'h44;
`endif
        tick("imm");
        chk("imm.op2", bus.op2, 8'h05);
        chk("imm.op1", bus.op1, fwd_exp);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_in(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 3'($urandom),
                   3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.ex_ready   = ($urandom_range(0, 9) < 7);
            bus.flush      = ($urandom_range(0, 9) == 0);
            bus.alu_result = 8'($urandom);
            set_wb(1'($urandom), 3'($urandom), 8'($urandom));
            tick("rand");
        end
        bus.flush = 0;

        // Asynchronous reset mid-cycle with a valid instruction held.
        set_in(8'hD1, 8'hD2, 8'h00, 0, 3'd5, 3'd1, 3'd2, 3'd7, 1);
        bus.ex_ready = 1;
        tick("pre_reset");
        chk("pre_reset.ex_valid", bus.ex_valid, 1);
        #3 rst_n = 0;
        #1;
        model_reset();
        check_all("async_reset");
        chk("async_reset.in_ready", bus.in_ready, 1);
        @(posedge clk); #3;
        rst_n = 1;
        #1;
        chk("reset_exit.ex_valid", bus.ex_valid, 0);
        chk("reset_exit.in_ready", bus.in_ready, 1);
        bus.in_valid = 0;
        tick("resume_idle");
        set_in(8'hE1, 8'hE2, 8'h00, 0, 3'd3, 3'd1, 3'd2, 3'd1, 0);
        tick("resume_load");
        chk("resume_load.op1", bus.op1, 8'hE1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter W, default 8, the datapath width of operands and results.
REQ-002 SHALL have parameter RA, default 3, the register-address width (8 registers; r0 reads as zero).
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid in 1 and in_ready out 1  upstream (decode) handshake.
REQ-006 SHALL have ports in_rs_val in W and in_rt_val in W  register-file read data.
REQ-007 SHALL have ports in_imm in W and in_use_imm in 1  immediate and its op2 select.
REQ-008 SHALL have ports in_func in 3, in_rs in RA, in_rt in RA, in_rd in RA, in_wen in 1  decoded instruction fields.
REQ-009 SHALL have ports wb_wen in 1, wb_rd in RA, wb_data in W  writeback bus.
REQ-010 SHALL have port alu_result  in  W  combinational ALU result for the held instruction.
REQ-011 SHALL have ports flush in 1 and ex_ready in 1  pipeline flush and downstream ready.
REQ-012 SHALL have ports op1 out W, op2 out W, func out 3  registered ALU operands and function.
REQ-013 SHALL have ports ex_valid out 1, ex_rd out RA, ex_wen out 1  held-instruction status.

Function
REQ-014 SHALL drive in_ready = !ex_valid || ex_ready (combinational).
REQ-015 SHALL load a new instruction when in_valid && in_ready && !flush; ex_valid then 1 next cycle.
REQ-016 SHALL clear ex_valid when ex_ready && !(in_valid && in_ready), and hold all registers when ex_valid && !ex_ready.
REQ-017 SHALL give flush priority over load: on flush, ex_valid=0 and ex_wen=0 next cycle, incoming instruction discarded.
REQ-018 SHALL load op2 = in_imm when in_use_imm=1, else the (possibly forwarded) rt operand.
REQ-019 SHALL load func, ex_rd, ex_wen from in_func, in_rd, in_wen; latency in->op1/op2 exactly one cycle.
REQ-020 SHALL never forward to, or mark as writing, register 0 (rd==0 treated as ex_wen=0 for hazards).
REQ-021 SHALL keep outputs stable while stalled regardless of alu_result/wb changes.

Reset
REQ-022 SHALL, while rst_n=0, force op1=0, op2=0, func=0, ex_rd=0, ex_wen=0, ex_valid=0 immediately.
REQ-023 SHALL, on rst_n rising mid-transfer, resume with ex_valid=0 and in_ready=1; no pre-reset instruction survives.

Configuration
REQ-024 SHALL implement operand forwarding only when macro ID_EX_FORWARD_EN is defined.
REQ-025 SHALL, with ID_EX_FORWARD_EN, per source (rs, rt): use alu_result if ex_valid && ex_wen && ex_rd==src && src!=0; else wb_data if wb_wen && wb_rd==src && src!=0; else in_*_val (EX over WB).
REQ-026 SHALL, without ID_EX_FORWARD_EN, latch in_rs_val/in_rt_val unmodified and ignore alu_result, wb_* inputs.

Verification
REQ-027 Reset: rst_n=0 mid-cycle with ex_valid=1 -> all outputs 0 without waiting for clk.
REQ-028 Basic: in_rs_val=0xF8, in_rt_val=0x01, in_func=2, in_valid=1, ex_ready=1 -> next cycle op1=0xF8, op2=0x01, func=2, ex_valid=1.
REQ-029 Stall: ex_valid=1, ex_ready=0, in_valid=1 -> in_ready=0, op1/op2/func unchanged for 3 cycles; ex_ready=1 -> new instruction loaded next edge.
REQ-030 Flush: flush=1 with in_valid=1, in_ready=1 -> next cycle ex_valid=0, ex_wen=0.
REQ-031 Forwarding (ID_EX_FORWARD_EN): held ex_rd=3, ex_wen=1, alu_result=0x7F; wb_rd=3, wb_data=0x11; new in_rs=3, in_rs_val=0x00 -> op1=0x7F; with in_rs=0 -> op1=in_rs_val.
REQ-032 Immediate/no-forward: in_use_imm=1, in_imm=0x05, rt hazard present -> op2=0x05; without macro same hazard case -> op1=in_rs_val.
